// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants shared by the instruction assembler.
package rv_isa_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_I,
    FMT_S,
    FMT_SB,
    FMT_UJ,
    FMT_U,
    FMT_R,
    FMT_BAD
  } fmt_e;

  // addi x0,x0,0 -- emitted in place of any rejected request
  localparam logic [31:0] NOP = 32'h00000013;

  localparam logic [1:0] ERR_OK     = 2'd0;
  localparam logic [1:0] ERR_OPCODE = 2'd1;
  localparam logic [1:0] ERR_RANGE  = 2'd2;
  localparam logic [1:0] ERR_ALIGN  = 2'd3;

  // Signed inclusive range test on the raw 32-bit immediate
  function automatic logic in_range(input logic signed [31:0] v,
                                    input logic signed [31:0] lo,
                                    input logic signed [31:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response bundle for the instruction assembler, plus its counters.
interface instr_encoder_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       in_opcode;
  logic [4:0]       in_rd;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [2:0]       in_funct3;
  logic [6:0]       in_funct7;
  logic [31:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [1:0]       out_err;
  logic [CNT_W-1:0] cnt_ok;
  logic [CNT_W-1:0] cnt_err;

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    input  out_ready,
    output in_ready, out_valid, out_instr, out_err, cnt_ok, cnt_err
  );

  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    output out_ready,
    input  in_ready, out_valid, out_instr, out_err, cnt_ok, cnt_err
  );
endinterface

// File: rtl/instr_fmt_chk.sv
// Classifies an opcode into its encoding format and validates the immediate for it.
module instr_fmt_chk
  import rv_isa_pkg::*;
(
  input  logic [6:0]  i_opcode,
  input  logic [31:0] i_imm,
  output fmt_e        o_fmt,
  output logic [1:0]  o_err
);

  // Format decode and immediate checks; range violations take priority over alignment
  always_comb begin
    o_fmt = FMT_BAD;
    o_err = ERR_OPCODE;
    case (i_opcode)
      OP_LOAD, OP_IMM, OP_JALR: begin
        o_fmt = FMT_I;
        o_err = in_range(i_imm, -32'sd2048, 32'sd2047) ? ERR_OK : ERR_RANGE;
      end
      OP_STORE: begin
        o_fmt = FMT_S;
        o_err = in_range(i_imm, -32'sd2048, 32'sd2047) ? ERR_OK : ERR_RANGE;
      end
      OP_BRANCH: begin
        o_fmt = FMT_SB;
        if (!in_range(i_imm, -32'sd4096, 32'sd4094)) o_err = ERR_RANGE;
        else if (i_imm[0])                           o_err = ERR_ALIGN;
        else                                         o_err = ERR_OK;
      end
      OP_JAL: begin
        o_fmt = FMT_UJ;
        if (!in_range(i_imm, -32'sd1048576, 32'sd1048574)) o_err = ERR_RANGE;
        else if (i_imm[0])                                 o_err = ERR_ALIGN;
        else                                               o_err = ERR_OK;
      end
      OP_LUI: begin
        o_fmt = FMT_U;
        o_err = (i_imm[11:0] != 12'd0) ? ERR_ALIGN : ERR_OK;
      end
      OP_REG: begin
        o_fmt = FMT_R;
        o_err = ERR_OK;
      end
      default: begin
        o_fmt = FMT_BAD;
        o_err = ERR_OPCODE;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage streaming RV32I assembler: stage 1 registers fields and the check result,
// stage 2 holds the packed word until the consumer takes it.
module instr_encoder
  import rv_isa_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  instr_encoder_if.slave bus
);

  logic             w_s1_adv;
  logic             w_s2_adv;
  fmt_e             w_fmt;
  logic [1:0]       w_err;
  logic [31:0]      w_packed;

  logic             r_s1_valid;
  logic [6:0]       r_s1_opcode;
  logic [4:0]       r_s1_rd;
  logic [4:0]       r_s1_rs1;
  logic [4:0]       r_s1_rs2;
  logic [2:0]       r_s1_f3;
  logic [6:0]       r_s1_f7;
  logic [31:0]      r_s1_imm;
  fmt_e             r_s1_fmt;
  logic [1:0]       r_s1_err;

  logic             r_s2_valid;
  logic [31:0]      r_s2_instr;
  logic [1:0]       r_s2_err;

  logic [CNT_W-1:0] r_cnt_ok;
  logic [CNT_W-1:0] r_cnt_err;

  instr_fmt_chk u_fmt_chk (
    .i_opcode (bus.in_opcode),
    .i_imm    (bus.in_imm),
    .o_fmt    (w_fmt),
    .o_err    (w_err)
  );

  // A stage may load when it is empty or its content moves on this cycle
  assign w_s2_adv     = ~r_s2_valid | bus.out_ready;
  assign w_s1_adv     = ~r_s1_valid | w_s2_adv;
  assign bus.in_ready = w_s1_adv;

  // Stage 1: capture request fields together with the decoded format and error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_opcode <= '0;
      r_s1_rd     <= '0;
      r_s1_rs1    <= '0;
      r_s1_rs2    <= '0;
      r_s1_f3     <= '0;
      r_s1_f7     <= '0;
      r_s1_imm    <= '0;
      r_s1_fmt    <= FMT_BAD;
      r_s1_err    <= ERR_OK;
    end else if (w_s1_adv) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_opcode <= bus.in_opcode;
        r_s1_rd     <= bus.in_rd;
        r_s1_rs1    <= bus.in_rs1;
        r_s1_rs2    <= bus.in_rs2;
        r_s1_f3     <= bus.in_funct3;
        r_s1_f7     <= bus.in_funct7;
        r_s1_imm    <= bus.in_imm;
        r_s1_fmt    <= w_fmt;
        r_s1_err    <= w_err;
      end
    end
  end

  // Scatter immediate bits into the layout for the decoded format; rejected requests become NOP
  always_comb begin
    w_packed = NOP;
    if (r_s1_err == ERR_OK) begin
      case (r_s1_fmt)
        FMT_I:  w_packed = {r_s1_imm[11:0], r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_opcode};
        FMT_S:  w_packed = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_imm[4:0], r_s1_opcode};
        FMT_SB: w_packed = {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1, r_s1_f3,
                            r_s1_imm[4:1], r_s1_imm[11], r_s1_opcode};
        FMT_UJ: w_packed = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11], r_s1_imm[19:12],
                            r_s1_rd, r_s1_opcode};
        FMT_U:  w_packed = {r_s1_imm[31:12], r_s1_rd, r_s1_opcode};
        FMT_R:  w_packed = {r_s1_f7, r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_opcode};
        default: w_packed = NOP;
      endcase
    end
  end

  // Stage 2: output register, held while the consumer stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_instr <= '0;
      r_s2_err   <= ERR_OK;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_instr <= w_packed;
        r_s2_err   <= r_s1_err;
      end
    end
  end

  // Saturating handoff counters, split by outcome
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt_ok  <= '0;
      r_cnt_err <= '0;
    end else if (r_s2_valid && bus.out_ready) begin
      if (r_s2_err == ERR_OK) begin
        if (r_cnt_ok != '1) r_cnt_ok <= r_cnt_ok + CNT_W'(1);
      end else begin
        if (r_cnt_err != '1) r_cnt_err <= r_cnt_err + CNT_W'(1);
      end
    end
  end

  assign bus.out_valid = r_s2_valid;
  assign bus.out_instr = r_s2_instr;
  assign bus.out_err   = r_s2_err;
  assign bus.cnt_ok    = r_cnt_ok;
  assign bus.cnt_err   = r_cnt_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed encodings, stall/back-to-back flow, mid-stream reset,
// counter saturation and a randomized stream against a reference assembler model.
module tb_instr_encoder;

  localparam int CW   = 4;
  localparam int SATV = (1 << CW) - 1;
  localparam int NREQ = 300;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_encoder_if #(.CNT_W(CW)) bus ();
  instr_encoder #(.CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] instr;
    logic [1:0]  err;
  } dcase_t;

  // Reference assembler: range rules on the integer value of the immediate, then field layout
  function automatic void model_encode(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [2:0] f3, input logic [6:0] f7,
                                       input logic [31:0] imm,
                                       output logic [31:0] ins, output logic [1:0] err);
    longint v;
    logic [31:0] u;
    v   = longint'($signed(imm));
    u   = imm;
    ins = 32'h00000013;
    err = 2'd0;
    case (op)
      7'h03, 7'h13, 7'h67:
        if (v < -2048 || v > 2047) err = 2'd2;
        else ins = {u[11:0], rs1, f3, rd, op};
      7'h23:
        if (v < -2048 || v > 2047) err = 2'd2;
        else ins = {u[11:5], rs2, rs1, f3, u[4:0], op};
      7'h63:
        if (v < -4096 || v > 4094) err = 2'd2;
        else if (v % 2 != 0)       err = 2'd3;
        else ins = {u[12], u[10:5], rs2, rs1, f3, u[4:1], u[11], op};
      7'h6F:
        if (v < -1048576 || v > 1048574) err = 2'd2;
        else if (v % 2 != 0)             err = 2'd3;
        else ins = {u[20], u[10:1], u[11], u[19:12], rd, op};
      7'h37:
        if (u % 4096 != 0) err = 2'd3;
        else ins = {u[31:12], rd, op};
      7'h33: ins = {f7, rs2, rs1, f3, rd, op};
      default: err = 2'd1;
    endcase
    if (err != 2'd0) ins = 32'h00000013;
  endfunction

  task automatic clear_req();
    bus.in_valid  = 1'b0;
    bus.in_opcode = '0;
    bus.in_rd     = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_funct3 = '0;
    bus.in_funct7 = '0;
    bus.in_imm    = '0;
  endtask

  task automatic do_reset();
    clear_req();
    bus.out_ready = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_req();
    bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_instr !== 32'h0) begin errors++; $display("FAIL rst_out_instr: got %h expected 00000000", bus.out_instr); end
    checks++; if (bus.out_err !== 2'd0) begin errors++; $display("FAIL rst_out_err: got %0d expected 0", bus.out_err); end
    checks++; if (bus.cnt_ok !== '0) begin errors++; $display("FAIL rst_cnt_ok: got %0d expected 0", bus.cnt_ok); end
    checks++; if (bus.cnt_err !== '0) begin errors++; $display("FAIL rst_cnt_err: got %0d expected 0", bus.cnt_err); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    dcase_t dc[11];
    dc[0]  = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,    32'hFFFFFFFF, 32'hFFF00093, 2'd0};
    dc[1]  = '{7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0,    32'd8,        32'h0020A423, 2'd0};
    dc[2]  = '{7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,    32'hFFFFFFFC, 32'hFE000EE3, 2'd0};
    dc[3]  = '{7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,    32'd0,        32'h0000006F, 2'd0};
    dc[4]  = '{7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0,    32'h12345000, 32'h123452B7, 2'd0};
    dc[5]  = '{7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0,    32'h12345001, 32'h00000013, 2'd3};
    dc[6]  = '{7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,    32'd4096,     32'h00000013, 2'd2};
    dc[7]  = '{7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,    32'd3,        32'h00000013, 2'd3};
    dc[8]  = '{7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0,    32'd0,        32'h00000013, 2'd1};
    dc[9]  = '{7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20,   32'd0,        32'h402081B3, 2'd0};
    dc[10] = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,    32'd2048,     32'h00000013, 2'd2};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_opcode = dc[i].op;
      bus.in_rd     = dc[i].rd;
      bus.in_rs1    = dc[i].rs1;
      bus.in_rs2    = dc[i].rs2;
      bus.in_funct3 = dc[i].f3;
      bus.in_funct7 = dc[i].f7;
      bus.in_imm    = dc[i].imm;
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_in_ready: got %b expected 1", i, bus.in_ready); end
      @(posedge clk);
      #1;
      clear_req();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_latency_early: out_valid %b expected 0", i, bus.out_valid); end
      @(posedge clk);
      #1;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL dir%0d_latency: out_valid %b expected 1", i, bus.out_valid); end
      checks++; if (bus.out_instr !== dc[i].instr) begin errors++; $display("FAIL dir%0d_instr: got %h expected %h", i, bus.out_instr, dc[i].instr); end
      checks++; if (bus.out_err !== dc[i].err) begin errors++; $display("FAIL dir%0d_err: got %0d expected %0d", i, bus.out_err, dc[i].err); end
      @(posedge clk);
      #1;
    end
    checks++; if (bus.cnt_ok !== CW'(6)) begin errors++; $display("FAIL dir_cnt_ok: got %0d expected 6", bus.cnt_ok); end
    checks++; if (bus.cnt_err !== CW'(5)) begin errors++; $display("FAIL dir_cnt_err: got %0d expected 5", bus.cnt_err); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q_i[$];
    logic [31:0] e_i;
    logic [1:0]  e_e;
    logic        exp_rdy;
    logic        saw_stall;
    int sent, got, occ;
    sent = 0; got = 0; saw_stall = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      bus.out_ready = !(cyc >= 3 && cyc <= 6);
      if (sent < 8) begin
        bus.in_valid  = 1'b1;
        bus.in_opcode = 7'h13;
        bus.in_rd     = 5'(sent + 1);
        bus.in_rs1    = 5'(sent);
        bus.in_rs2    = 5'd0;
        bus.in_funct3 = 3'(sent);
        bus.in_funct7 = 7'd0;
        bus.in_imm    = 32'(sent * 100 - 350);
      end else begin
        clear_req();
      end
      @(negedge clk);
      occ = sent - got;
      exp_rdy = !(occ == 2 && !bus.out_ready);
      if (!exp_rdy) saw_stall = 1'b1;
      checks++; if (bus.in_ready !== exp_rdy) begin errors++; $display("FAIL b2b_in_ready cyc%0d: got %b expected %b", cyc, bus.in_ready, exp_rdy); end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (q_i.size() == 0) begin errors++; $display("FAIL b2b_extra_output: got %h expected none", bus.out_instr); end
        else begin
          e_i = q_i.pop_front();
          if (bus.out_instr !== e_i) begin errors++; $display("FAIL b2b_instr%0d: got %h expected %h", got, bus.out_instr, e_i); end
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        model_encode(bus.in_opcode, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_funct3,
                     bus.in_funct7, bus.in_imm, e_i, e_e);
        q_i.push_back(e_i);
        sent++;
      end
      @(posedge clk);
      #1;
    end
    clear_req();
    checks++; if (got != 8) begin errors++; $display("FAIL b2b_count: got %0d expected 8", got); end
    checks++; if (saw_stall !== 1'b1) begin errors++; $display("FAIL b2b_full_stall: got %b expected 1", saw_stall); end
    checks++; if (bus.cnt_ok !== CW'(8)) begin errors++; $display("FAIL b2b_cnt_ok: got %0d expected 8", bus.cnt_ok); end
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_opcode = 7'h13;
      bus.in_rd     = 5'(i + 4);
      bus.in_imm    = 32'(i);
      @(posedge clk);
      #1;
    end
    clear_req();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_inflight: out_valid %b expected 1", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_full_ready: got %b expected 0", bus.in_ready); end
    reset = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_instr !== 32'h0) begin errors++; $display("FAIL mid_out_instr: got %h expected 00000000", bus.out_instr); end
    checks++; if (bus.cnt_ok !== '0) begin errors++; $display("FAIL mid_cnt_ok: got %0d expected 0", bus.cnt_ok); end
    checks++; if (bus.cnt_err !== '0) begin errors++; $display("FAIL mid_cnt_err: got %0d expected 0", bus.cnt_err); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b expected 1", bus.in_ready); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_dropped%0d: out_valid %b expected 0", i, bus.out_valid); end
    end
  endtask

  task automatic test_saturation();
    int acc;
    acc = 0;
    do_reset();
    for (int cyc = 0; cyc < 100 && acc < 17; cyc++) begin
      bus.in_valid  = 1'b1;
      bus.in_opcode = 7'h7F;
      bus.in_imm    = 32'(cyc);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) acc++;
      @(posedge clk);
      #1;
    end
    clear_req();
    repeat (4) @(posedge clk);
    #1;
    checks++; if (acc != 17) begin errors++; $display("FAIL sat_accepts: got %0d expected 17", acc); end
    checks++; if (bus.cnt_err !== CW'(SATV)) begin errors++; $display("FAIL sat_cnt_err: got %h expected %h", bus.cnt_err, CW'(SATV)); end
    checks++; if (bus.cnt_ok !== '0) begin errors++; $display("FAIL sat_cnt_ok: got %0d expected 0", bus.cnt_ok); end
  endtask

  task automatic test_random();
    logic [31:0] q_i[$];
    logic [1:0]  q_e[$];
    logic [31:0] e_i, held_i;
    logic [1:0]  e_e, held_e;
    logic        pend, prev_stall, exp_rdy;
    logic [6:0]  ops[9];
    int          bnd[18];
    int sent, got, exp_ok, exp_err, occ, s;
    ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h33, 7'h00};
    bnd = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096,
            -1048577, -1048576, 1048574, 1048575, 1048576, 32'h12345000, 4096, 1, 3};
    sent = 0; got = 0; exp_ok = 0; exp_err = 0;
    pend = 1'b0; prev_stall = 1'b0; held_i = '0; held_e = '0;
    do_reset();
    for (int cyc = 0; cyc < 5000 && got < NREQ; cyc++) begin
      if (!pend && sent < NREQ && ($urandom % 4 != 0)) begin
        s = $urandom % 9;
        bus.in_opcode = (s == 8) ? 7'($urandom) : ops[s];
        bus.in_rd     = 5'($urandom);
        bus.in_rs1    = 5'($urandom);
        bus.in_rs2    = 5'($urandom);
        bus.in_funct3 = 3'($urandom);
        bus.in_funct7 = 7'($urandom);
        case ($urandom % 4)
          0: bus.in_imm = 32'(bnd[$urandom % 18]);
          1: bus.in_imm = 32'(int'($urandom_range(0, 8191)) - 4096);
          2: bus.in_imm = $urandom;
          default: bus.in_imm = ($urandom & 32'hFFFFF000) | 32'($urandom % 2);
        endcase
        pend = 1'b1;
      end
      bus.in_valid  = pend;
      bus.out_ready = ($urandom % 3 != 0);
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_instr !== held_i || bus.out_err !== held_e) begin
          errors++;
          $display("FAIL rnd_hold: got v%b %h/%0d expected v1 %h/%0d", bus.out_valid, bus.out_instr, bus.out_err, held_i, held_e);
        end
      end
      occ = sent - got;
      exp_rdy = !(occ == 2 && !bus.out_ready);
      checks++; if (bus.in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_in_ready cyc%0d: got %b expected %b", cyc, bus.in_ready, exp_rdy); end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (q_i.size() == 0) begin errors++; $display("FAIL rnd_extra_output: got %h expected none", bus.out_instr); end
        else begin
          e_i = q_i.pop_front();
          e_e = q_e.pop_front();
          if (bus.out_instr !== e_i || bus.out_err !== e_e) begin
            errors++;
            $display("FAIL rnd_out%0d: got %h/%0d expected %h/%0d", got, bus.out_instr, bus.out_err, e_i, e_e);
          end
          if (e_e == 2'd0) begin if (exp_ok < SATV) exp_ok++; end
          else begin if (exp_err < SATV) exp_err++; end
        end
        got++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      held_i = bus.out_instr;
      held_e = bus.out_err;
      if (bus.in_valid && bus.in_ready) begin
        model_encode(bus.in_opcode, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_funct3,
                     bus.in_funct7, bus.in_imm, e_i, e_e);
        q_i.push_back(e_i);
        q_e.push_back(e_e);
        sent++;
        pend = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    clear_req();
    checks++; if (got != NREQ) begin errors++; $display("FAIL rnd_count: got %0d expected %0d", got, NREQ); end
    checks++; if (bus.cnt_ok !== CW'(exp_ok)) begin errors++; $display("FAIL rnd_cnt_ok: got %0d expected %0d", bus.cnt_ok, exp_ok); end
    checks++; if (bus.cnt_err !== CW'(exp_err)) begin errors++; $display("FAIL rnd_cnt_err: got %0d expected %0d", bus.cnt_err, exp_err); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_req();
    bus.out_ready = 1'b0;
    reset = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midstream();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
